// File: rtl/xgmii_fifo.sv
// ----------------------------------------------------------------------------
// xgmii_fifo
//
// Single-clock, first-word-fall-through FIFO for XGMII words. Each entry holds
// one data word plus its per-byte-lane control bits, stored and returned
// bit-exact. When the FIFO is empty the read side presents the XGMII idle
// pattern (0x07 in every byte, all control bits set). With IDLE_FILL=1 the
// idle is offered as a valid word; with IDLE_FILL=0 out_ena drops instead.
// Writes arriving while the FIFO is full are discarded and counted.
//
// Handshake semantics (both sides):
//   A word moves across an interface on a rising clk edge where the source's
//   enable (in_ena / out_ena) and the sink's ready (in_rdy / out_rdy) are
//   both high. On the read side an idle presented while empty is never a
//   transfer: the pop additionally needs level > 0. On the write side an
//   enable with in_rdy low is not stalled; the word is dropped and counted.
//
// Parameters:
//   WIDTH     - data width in bits (32 or 64); ctrl width is WIDTH/8
//   DEPTH     - storage depth in words (power of 2, >= 4)
//   IDLE_FILL - 1: present a valid idle when empty; 0: deassert out_ena
//
// Ports:
//   clk       - clock for all logic
//   rst       - synchronous, active-high reset
//   in_data   - write-side data
//   in_ctrl   - write-side control, one bit per byte lane
//   in_ena    - write-side word valid
//   in_rdy    - write side can accept a word (level != DEPTH)
//   out_data  - read-side data (oldest word, or idle when empty)
//   out_ctrl  - read-side control
//   out_ena   - read-side word valid
//   out_rdy   - read-side sink accepts a word
//   level     - number of stored words
//   drop_cnt  - saturating count of words dropped on overflow
// ----------------------------------------------------------------------------
module xgmii_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int IDLE_FILL = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [WIDTH/8-1:0]         in_ctrl,
    input  logic                       in_ena,
    output logic                       in_rdy,
    output logic [WIDTH-1:0]           out_data,
    output logic [WIDTH/8-1:0]         out_ctrl,
    output logic                       out_ena,
    input  logic                       out_rdy,
    output logic [$clog2(DEPTH):0]     level,
    output logic [15:0]                drop_cnt
);

    localparam int CW = WIDTH / 8;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = WIDTH + CW;

    localparam logic [LW-1:0]    LEVEL_FULL = LW'(DEPTH);
    localparam logic [WIDTH-1:0] IDLE_DATA  = {CW{8'h07}};
    localparam logic [CW-1:0]    IDLE_CTRL  = {CW{1'b1}};

    // Storage: data and ctrl kept side by side in one entry so they can never
    // drift apart.
    logic [EW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic [15:0]   drop_q;

    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          drop;
    logic [EW-1:0] head;

    // ------------------------------------------------------------------------
    // Status and transfer decode. in_rdy comes from registered level only, so
    // a full FIFO refuses a write even if a pop happens in the same cycle.
    // ------------------------------------------------------------------------
    assign empty = (level_q == '0);
    assign full  = (level_q == LEVEL_FULL);

    assign in_rdy = !full;
    assign push   = in_ena && !full;
    assign drop   = in_ena && full;

    // Idle words are never popped: an empty FIFO ignores out_rdy.
    assign pop    = out_ena && out_rdy && !empty;

    // ------------------------------------------------------------------------
    // Read side: first-word-fall-through from the head entry, idle when empty.
    // ------------------------------------------------------------------------
    assign head = mem[rd_ptr];

    always_comb begin
        out_data = IDLE_DATA;
        out_ctrl = IDLE_CTRL;
        if (!empty) begin
            out_data = head[WIDTH-1:0];
            out_ctrl = head[EW-1:WIDTH];
        end
    end

    generate
        if (IDLE_FILL != 0) begin : g_idle_fill
            assign out_ena = 1'b1;
        end else begin : g_idle_gap
            assign out_ena = !empty;
        end
    endgenerate

    assign level    = level_q;
    assign drop_cnt = drop_q;

    // ------------------------------------------------------------------------
    // Storage write. Not reset: reset empties the FIFO through the pointers
    // and level, so stale entries are unreachable afterwards.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= {in_ctrl, in_data};
        end
    end

    // ------------------------------------------------------------------------
    // Pointers. Both are AW bits wide and wrap naturally modulo DEPTH, which
    // is a power of two, so there is no bubble at the wrap point.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Occupancy counter, kept separately from the pointers so full and empty
    // are unambiguous when the pointers are equal.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            unique case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Overflow counter: one count per refused write, holding at 0xFFFF.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else if (drop && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_xgmii_fifo.sv
// ----------------------------------------------------------------------------
// tb_xgmii_fifo
//
// Directed bench for xgmii_fifo. Two instances share clock and reset:
//   dut_a : WIDTH=32, DEPTH=16, IDLE_FILL=1
//   dut_b : WIDTH=64, DEPTH=16, IDLE_FILL=0
// Inputs change 1 ns after a rising edge; outputs are checked 1 ns after an
// edge, well away from the next one.
// ----------------------------------------------------------------------------
module tb_xgmii_fifo;

  logic clk;
  logic rst;

  // dut_a (32-bit, idle fill)
  logic [31:0] a_in_data;
  logic [3:0]  a_in_ctrl;
  logic        a_in_ena;
  logic        a_in_rdy;
  logic [31:0] a_out_data;
  logic [3:0]  a_out_ctrl;
  logic        a_out_ena;
  logic        a_out_rdy;
  logic [4:0]  a_level;
  logic [15:0] a_drop_cnt;

  // dut_b (64-bit, gap when empty)
  logic [63:0] b_in_data;
  logic [7:0]  b_in_ctrl;
  logic        b_in_ena;
  logic        b_in_rdy;
  logic [63:0] b_out_data;
  logic [7:0]  b_out_ctrl;
  logic        b_out_ena;
  logic        b_out_rdy;
  logic [4:0]  b_level;
  logic [15:0] b_drop_cnt;

  int total;
  int bad;

  xgmii_fifo #(.WIDTH(32), .DEPTH(16), .IDLE_FILL(1)) dut_a (
    .clk      (clk),
    .rst      (rst),
    .in_data  (a_in_data),
    .in_ctrl  (a_in_ctrl),
    .in_ena   (a_in_ena),
    .in_rdy   (a_in_rdy),
    .out_data (a_out_data),
    .out_ctrl (a_out_ctrl),
    .out_ena  (a_out_ena),
    .out_rdy  (a_out_rdy),
    .level    (a_level),
    .drop_cnt (a_drop_cnt)
  );

  xgmii_fifo #(.WIDTH(64), .DEPTH(16), .IDLE_FILL(0)) dut_b (
    .clk      (clk),
    .rst      (rst),
    .in_data  (b_in_data),
    .in_ctrl  (b_in_ctrl),
    .in_ena   (b_in_ena),
    .in_rdy   (b_in_rdy),
    .out_data (b_out_data),
    .out_ctrl (b_out_ctrl),
    .out_ena  (b_out_ena),
    .out_rdy  (b_out_rdy),
    .level    (b_level),
    .drop_cnt (b_drop_cnt)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic a_push_val(input logic [31:0] d, input logic [3:0] c);
    a_in_data = d;
    a_in_ctrl = c;
    a_in_ena  = 1'b1;
  endtask

  task automatic a_idle_in();
    a_in_data = '0;
    a_in_ctrl = '0;
    a_in_ena  = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    a_idle_in();
    a_out_rdy = 1'b1;
    b_in_data = '0;
    b_in_ctrl = '0;
    b_in_ena  = 1'b0;
    b_out_rdy = 1'b0;
    tick();
    tick();
    // values while reset is held
    total++;
    if (a_level !== 5'd0) begin bad++; $display("FAIL rst_level got=%0d exp=0", a_level); end
    total++;
    if (a_in_rdy !== 1'b1) begin bad++; $display("FAIL rst_in_rdy got=%b exp=1", a_in_rdy); end
    total++;
    if (a_drop_cnt !== 16'd0) begin bad++; $display("FAIL rst_drop got=%0d exp=0", a_drop_cnt); end
    total++;
    if (b_out_ena !== 1'b0) begin bad++; $display("FAIL rst_b_out_ena got=%b exp=0", b_out_ena); end
    total++;
    if (b_out_data !== 64'h0707070707070707 || b_out_ctrl !== 8'hFF) begin
      bad++; $display("FAIL rst_b_idle got=%h/%h exp=0707070707070707/ff", b_out_data, b_out_ctrl);
    end
    rst = 1'b0;
    // idle every cycle after release, out_rdy held high
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (a_out_data !== 32'h07070707 || a_out_ctrl !== 4'hF || a_out_ena !== 1'b1 || a_level !== 5'd0) begin
        bad++;
        $display("FAIL idle_cycle%0d got=%h/%h/%b/%0d exp=07070707/f/1/0",
                 i, a_out_data, a_out_ctrl, a_out_ena, a_level);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_order();
    logic [31:0] words [3];
    words[0] = 32'h11111111;
    words[1] = 32'h22222222;
    words[2] = 32'h33333333;
    a_out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_push_val(words[i], 4'h0);
      tick();
    end
    a_idle_in();
    total++;
    if (a_level !== 5'd3) begin bad++; $display("FAIL order_level got=%0d exp=3", a_level); end
    a_out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (a_out_data !== words[i] || a_out_ctrl !== 4'h0 || a_out_ena !== 1'b1) begin
        bad++;
        $display("FAIL order_word%0d got=%h/%h/%b exp=%h/0/1", i, a_out_data, a_out_ctrl, a_out_ena, words[i]);
      end
      tick();
    end
    total++;
    if (a_out_data !== 32'h07070707 || a_out_ctrl !== 4'hF || a_level !== 5'd0) begin
      bad++; $display("FAIL order_idle_after got=%h/%h/%0d exp=07070707/f/0", a_out_data, a_out_ctrl, a_level);
    end
  endtask

  // --------------------------------------------------------------------------
  // Pointers start at 3 here, so the 16 stored words wrap the ring.
  task automatic test_overflow();
    a_out_rdy = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      a_push_val(32'hA0000000 + 32'(i), 4'(i));
      tick();
    end
    a_idle_in();
    total++;
    if (a_level !== 5'd16) begin bad++; $display("FAIL ovf_level got=%0d exp=16", a_level); end
    total++;
    if (a_in_rdy !== 1'b0) begin bad++; $display("FAIL ovf_in_rdy got=%b exp=0", a_in_rdy); end
    total++;
    if (a_drop_cnt !== 16'd2) begin bad++; $display("FAIL ovf_drop got=%0d exp=2", a_drop_cnt); end
    a_out_rdy = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      total++;
      if (a_out_data !== 32'hA0000000 + 32'(i) || a_out_ctrl !== 4'(i)) begin
        bad++;
        $display("FAIL ovf_drain%0d got=%h/%h exp=%h/%h", i, a_out_data, a_out_ctrl,
                 32'hA0000000 + 32'(i), 4'(i));
      end
      tick();
    end
    total++;
    if (a_level !== 5'd0 || a_out_data !== 32'h07070707) begin
      bad++; $display("FAIL ovf_empty got=%0d/%h exp=0/07070707", a_level, a_out_data);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_full_push_pop();
    a_out_rdy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a_push_val(32'hB0000000 + 32'(i), 4'h5);
      tick();
    end
    // full: push attempt and pop in the same cycle
    a_push_val(32'hDEADDEAD, 4'hA);
    a_out_rdy = 1'b1;
    tick();
    a_idle_in();
    a_out_rdy = 1'b0;
    total++;
    if (a_level !== 5'd15) begin bad++; $display("FAIL full_pp_level got=%0d exp=15", a_level); end
    total++;
    if (a_drop_cnt !== 16'd3) begin bad++; $display("FAIL full_pp_drop got=%0d exp=3", a_drop_cnt); end
    total++;
    if (a_in_rdy !== 1'b1) begin bad++; $display("FAIL full_pp_in_rdy got=%b exp=1", a_in_rdy); end
    total++;
    if (a_out_data !== 32'hB0000001) begin bad++; $display("FAIL full_pp_head got=%h exp=b0000001", a_out_data); end
    // simultaneous push/pop below full keeps level and order
    a_push_val(32'hC0000000, 4'h3);
    a_out_rdy = 1'b1;
    tick();
    a_idle_in();
    a_out_rdy = 1'b0;
    total++;
    if (a_level !== 5'd15 || a_out_data !== 32'hB0000002) begin
      bad++; $display("FAIL mid_pp got=%0d/%h exp=15/b0000002", a_level, a_out_data);
    end
    // drain and confirm the refused word never entered and the late one is last
    a_out_rdy = 1'b1;
    for (int i = 2; i < 16; i++) begin
      total++;
      if (a_out_data !== 32'hB0000000 + 32'(i) || a_out_ctrl !== 4'h5) begin
        bad++; $display("FAIL full_drain%0d got=%h/%h exp=%h/5", i, a_out_data, a_out_ctrl, 32'hB0000000 + 32'(i));
      end
      tick();
    end
    total++;
    if (a_out_data !== 32'hC0000000 || a_out_ctrl !== 4'h3 || a_level !== 5'd1) begin
      bad++; $display("FAIL full_last got=%h/%h/%0d exp=c0000000/3/1", a_out_data, a_out_ctrl, a_level);
    end
    tick();
    total++;
    if (a_level !== 5'd0) begin bad++; $display("FAIL full_empty got=%0d exp=0", a_level); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_mid();
    a_out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_push_val(32'hE0000000 + 32'(i), 4'h1);
      tick();
    end
    total++;
    if (a_level !== 5'd5) begin bad++; $display("FAIL rmid_pre_level got=%0d exp=5", a_level); end
    // reset while still pushing
    rst = 1'b1;
    a_push_val(32'hE0000005, 4'h1);
    a_out_rdy = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (a_level !== 5'd0 || a_drop_cnt !== 16'd0 || a_in_rdy !== 1'b1) begin
      bad++; $display("FAIL rmid_state got=%0d/%0d/%b exp=0/0/1", a_level, a_drop_cnt, a_in_rdy);
    end
    total++;
    if (a_out_data !== 32'h07070707 || a_out_ctrl !== 4'hF || a_out_ena !== 1'b1) begin
      bad++; $display("FAIL rmid_idle got=%h/%h/%b exp=07070707/f/1", a_out_data, a_out_ctrl, a_out_ena);
    end
    // next push, with out_rdy high at level 0, only pushes
    a_push_val(32'hCAFEF00D, 4'h2);
    tick();
    a_idle_in();
    a_out_rdy = 1'b0;
    total++;
    if (a_level !== 5'd1 || a_out_data !== 32'hCAFEF00D || a_out_ctrl !== 4'h2) begin
      bad++; $display("FAIL rmid_next got=%0d/%h/%h exp=1/cafef00d/2", a_level, a_out_data, a_out_ctrl);
    end
    a_out_rdy = 1'b1;
    tick();
    total++;
    if (a_level !== 5'd0 || a_out_data !== 32'h07070707) begin
      bad++; $display("FAIL rmid_residual got=%0d/%h exp=0/07070707", a_level, a_out_data);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_back_to_back_64();
    logic [63:0] exp_q [$];
    logic [63:0] w;
    exp_q = {};
    b_out_rdy = 1'b1;
    total++;
    if (b_out_ena !== 1'b0 || b_level !== 5'd0) begin
      bad++; $display("FAIL b2b_pre got=%b/%0d exp=0/0", b_out_ena, b_level);
    end
    for (int k = 0; k < 8; k++) begin
      w = {32'hDEAD0000 | 32'(k), 32'h0000BEEF ^ 32'(k)};
      b_in_data = w;
      b_in_ctrl = 8'(k);
      b_in_ena  = 1'b1;
      exp_q.push_back(w);
      tick();
      total++;
      if (b_out_ena !== 1'b1 || b_level !== 5'd1 || b_out_data !== exp_q[0] || b_out_ctrl !== 8'(k)) begin
        bad++;
        $display("FAIL b2b_word%0d got=%b/%0d/%h/%h exp=1/1/%h/%h",
                 k, b_out_ena, b_level, b_out_data, b_out_ctrl, exp_q[0], 8'(k));
      end
      void'(exp_q.pop_front());
    end
    b_in_ena = 1'b0;
    tick();
    total++;
    if (b_out_ena !== 1'b0 || b_level !== 5'd0 || b_out_data !== 64'h0707070707070707) begin
      bad++; $display("FAIL b2b_end got=%b/%0d/%h exp=0/0/0707070707070707", b_out_ena, b_level, b_out_data);
    end
  endtask

  // --------------------------------------------------------------------------
  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    a_idle_in();
    a_out_rdy = 1'b0;
    b_in_data = '0;
    b_in_ctrl = '0;
    b_in_ena  = 1'b0;
    b_out_rdy = 1'b0;

    test_reset();
    test_order();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_back_to_back_64();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xgmii_fifo.md
XGMII_FIFO -- requirements
Module: xgmii_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: XGMII data width in bits, a multiple of 8 (32 or 64 supported); ctrl width is WIDTH/8.
REQ-002 The block SHALL have parameter DEPTH, default 16: storage depth in words, a power of 2 and >= 4.
REQ-003 The block SHALL have parameter IDLE_FILL, default 1: 1 = present XGMII idle when empty; 0 = deassert out_ena when empty.
REQ-004 The block SHALL have port clk, input, 1: single clock for all logic.
REQ-005 The block SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 The block SHALL have port in_data, input, WIDTH: write-side XGMII data.
REQ-007 The block SHALL have port in_ctrl, input, WIDTH/8: write-side XGMII control, 1 bit per byte lane.
REQ-008 The block SHALL have port in_ena, input, 1: write-side word valid.
REQ-009 The block SHALL have port in_rdy, output, 1: write side can accept a word.
REQ-010 The block SHALL have port out_data, output, WIDTH: read-side XGMII data.
REQ-011 The block SHALL have port out_ctrl, output, WIDTH/8: read-side XGMII control.
REQ-012 The block SHALL have port out_ena, output, 1: read-side word valid.
REQ-013 The block SHALL have port out_rdy, input, 1: read-side sink accepts a word.
REQ-014 The block SHALL have port level, output, $clog2(DEPTH)+1: number of stored words.
REQ-015 The block SHALL have port drop_cnt, output, 16: saturating count of words dropped on overflow.

Function
REQ-016 A push SHALL occur on a clk edge with in_ena=1 and in_rdy=1; a pop SHALL occur on a clk edge with out_ena=1, out_rdy=1 and level>0.
REQ-017 in_rdy SHALL equal (level != DEPTH), from registered state only, with no lookahead on a same-cycle pop.
REQ-018 With in_ena=1 and in_rdy=0, the word SHALL be discarded, storage SHALL remain unchanged, and drop_cnt SHALL increment, saturating at 0xFFFF.
REQ-019 Read side SHALL be first-word-fall-through: when level>0, out_data/out_ctrl SHALL show the oldest word and out_ena=1.
REQ-020 Write-to-read latency SHALL be 1 cycle: a word pushed into an empty FIFO on edge N SHALL be visible on out_* after edge N.
REQ-021 IDLE_FILL=1 and level=0: out_ena SHALL be 1, every byte of out_data SHALL be 0x07, out_ctrl SHALL be all ones, and out_rdy=1 SHALL NOT change state.
REQ-022 IDLE_FILL=0 and level=0: out_ena SHALL be 0, and out_data/out_ctrl SHALL be the idle pattern of REQ-021.
REQ-023 Simultaneous push and pop with 0<level<DEPTH SHALL leave level unchanged and keep word order.
REQ-024 Push at level=0 together with out_rdy=1 SHALL only push, and the next cycle SHALL have level=1.
REQ-025 Pop at level=DEPTH with in_ena=1 SHALL pop only, drop the incoming word per REQ-018, and the next cycle SHALL have level=DEPTH-1 and in_rdy=1.
REQ-026 Read and write pointers SHALL be $clog2(DEPTH) bits, wrap modulo DEPTH with no bubble, and level SHALL be tracked as a separate counter.
REQ-027 Data and ctrl SHALL be stored together and passed bit-exact; the block SHALL NOT inspect XGMII content except to generate idles.

Reset
REQ-028 When rst=1 at a clk edge, pointers, level and drop_cnt SHALL clear to 0, and all stored words SHALL be discarded.
REQ-029 During and after reset: in_rdy=1, level=0, drop_cnt=0, out_* SHALL follow REQ-021/REQ-022 (IDLE_FILL=1: out_ena=1 with idle pattern).
REQ-030 rst SHALL take priority over a push or pop in the same cycle, and reset mid-packet SHALL flush partial data, with no residual words after release.

Verification
REQ-031 WIDTH=32, IDLE_FILL=1: after reset, with in_ena=0 and out_rdy=1 -> out_data=0x07070707, out_ctrl=0xF, out_ena=1, level=0 every cycle.
REQ-032 Push 0x11111111, 0x22222222, 0x33333333 (ctrl=0) with out_rdy=0 -> level=3; then out_rdy=1 -> same order out, and idle resumes after the 3rd word.
REQ-033 DEPTH=16: push 18 words with out_rdy=0 -> level=16, in_rdy=0, drop_cnt=2; drain 16 words -> words 1..16 intact across pointer wrap.
REQ-034 Full FIFO: in_ena=1 and out_rdy=1 together for 1 cycle -> level=15, drop_cnt+1, in_rdy=1 the next cycle.
REQ-035 Level=5: assert rst for 1 cycle while pushing -> level=0, drop_cnt=0, idle out, and the next push appears after 1 cycle.
REQ-036 WIDTH=64, IDLE_FILL=0, continuous push/pop with in_ena=out_rdy=1 -> level stays 1 at steady state, data bit-exact, and out_ena=0 only in the cycle before the first word.
